// File: rtl/ma3_channel_scheduler.sv
// Round-robin scheduler sharing one 4-term moving-sum datapath across NUM_CH sample streams.
// Each channel keeps its own 3-deep history and fill count; results are registered and channel-tagged.
module ma3_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
) (
  input  logic                       system1000,
  input  logic                       system1000_rst,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DATA_W-1:0]   req_data,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          clr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [DATA_W-1:0]   out_sum,
  output logic [CH_W-1:0]            out_ch,
  output logic                       out_primed
);

  // Handshake: a sample moves when req_valid[c] && req_ready[c]; a result
  // leaves when out_valid && out_ready. A new sample is only admitted when
  // the output register is empty or is being drained in the same cycle.

  logic                     r_out_valid;
  logic signed [DATA_W-1:0] r_out_sum;
  logic [CH_W-1:0]          r_out_ch;
  logic                     r_out_primed;
  logic [CH_W-1:0]          r_ptr;
  logic signed [DATA_W-1:0] r_h0 [NUM_CH];
  logic signed [DATA_W-1:0] r_h1 [NUM_CH];
  logic signed [DATA_W-1:0] r_h2 [NUM_CH];
  logic [1:0]               r_fill [NUM_CH];

  logic                     w_slot_free;
  logic [NUM_CH-1:0]        w_elig;
  logic                     w_found;
  logic [CH_W-1:0]          w_grant;
  logic [CH_W-1:0]          w_idx;
  logic [CH_W-1:0]          w_ptr_next;
  logic                     w_xfer;
  logic signed [DATA_W-1:0] w_sample;
  logic signed [DATA_W-1:0] w_sum;

  assign w_slot_free = !r_out_valid || out_ready;
  assign w_elig      = req_valid & ~clr & {NUM_CH{w_slot_free}};

  // Search ptr, ptr+1, ... modulo NUM_CH; first eligible channel wins.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = CH_W'((int'(r_ptr) + k) % NUM_CH);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_found && !system1000_rst) req_ready[w_grant] = 1'b1;
  end

  assign w_xfer     = w_found && !system1000_rst;
  assign w_ptr_next = (w_grant == CH_W'(NUM_CH - 1)) ? '0 : w_grant + CH_W'(1);
  assign w_sample   = req_data[int'(w_grant)*DATA_W +: DATA_W];
  // Plain DATA_W-wide addition gives the required two's-complement wrap.
  assign w_sum      = w_sample + r_h0[w_grant] + r_h1[w_grant] + r_h2[w_grant];

  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      r_out_valid  <= 1'b0;
      r_out_sum    <= '0;
      r_out_ch     <= '0;
      r_out_primed <= 1'b0;
      r_ptr        <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_h0[c]   <= '0;
        r_h1[c]   <= '0;
        r_h2[c]   <= '0;
        r_fill[c] <= 2'd0;
      end
    end else begin
      if (w_xfer) begin
        r_out_valid  <= 1'b1;
        r_out_sum    <= w_sum;
        r_out_ch     <= w_grant;
        r_out_primed <= (r_fill[w_grant] == 2'd3);
        r_ptr        <= w_ptr_next;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (clr[c]) begin
          r_h0[c]   <= '0;
          r_h1[c]   <= '0;
          r_h2[c]   <= '0;
          r_fill[c] <= 2'd0;
        end else if (w_xfer && (w_grant == CH_W'(c))) begin
          r_h2[c]   <= r_h1[c];
          r_h1[c]   <= r_h0[c];
          r_h0[c]   <= w_sample;
          r_fill[c] <= (r_fill[c] == 2'd3) ? 2'd3 : r_fill[c] + 2'd1;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_sum    = r_out_sum;
  assign out_ch     = r_out_ch;
  assign out_primed = r_out_primed;

endmodule

// File: tb/tb_ma3_channel_scheduler.sv
// Bench for ma3_channel_scheduler: directed scenarios plus random traffic, with a
// queue-based reference model of per-channel sample histories and round-robin order.
module tb_ma3_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 8;
  localparam int CH_W   = 2;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_CH-1:0]         req_valid = '0;
  logic [NUM_CH*DATA_W-1:0]  req_data = '0;
  logic [NUM_CH-1:0]         req_ready;
  logic [NUM_CH-1:0]         clr = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b0;
  logic signed [DATA_W-1:0]  out_sum;
  logic [CH_W-1:0]           out_ch;
  logic                      out_primed;

  int errors = 0;
  int checks = 0;

  logic [CH_W+DATA_W:0] exp_q[$];
  int                   m_hist[NUM_CH][$];
  int                   m_ptr;
  bit                   m_valid;
  logic [NUM_CH-1:0]    last_rdy;

  always #5 clk = ~clk;

  ma3_channel_scheduler #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .system1000     (clk),
    .system1000_rst (rst),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .clr            (clr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_ch         (out_ch),
    .out_primed     (out_primed)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_sum(input string name, input int exp);
    logic [7:0] e;
    logic [7:0] a;
    e = 8'(exp);
    a = out_sum;
    chk(name, {24'd0, a}, {24'd0, e});
  endtask

  task automatic set_sample(input int c, input int v);
    req_data[c*DATA_W +: DATA_W] = 8'(v);
  endtask

  task automatic model_clear();
    m_ptr   = 0;
    m_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) m_hist[c].delete();
    exp_q.delete();
  endtask

  // One clock: at the falling edge compare req_ready with the model's grant,
  // advance the model, then return just after the rising edge.
  task automatic cycle();
    int g;
    int c;
    int s;
    int sum;
    int n;
    logic [NUM_CH-1:0] er;
    @(negedge clk);
    g = -1;
    if (!m_valid || out_ready) begin
      for (int k = 0; k < NUM_CH; k++) begin
        c = (m_ptr + k) % NUM_CH;
        if (g < 0 && req_valid[c] && !clr[c]) g = c;
      end
    end
    er = (g >= 0) ? NUM_CH'(1 << g) : '0;
    last_rdy = req_ready;
    chk("req_ready", {28'd0, req_ready}, {28'd0, er});
    for (int k = 0; k < NUM_CH; k++) if (clr[k]) m_hist[k].delete();
    if (g >= 0) begin
      s = int'($signed(req_data[g*DATA_W +: DATA_W]));
      n = m_hist[g].size();
      sum = s;
      for (int i = n - 1; i >= 0 && i >= n - 3; i--) sum += m_hist[g][i];
      exp_q.push_back({(n >= 3) ? 1'b1 : 1'b0, 2'(g), 8'(sum)});
      m_hist[g].push_back(s);
      if (m_hist[g].size() > 3) void'(m_hist[g].pop_front());
      m_ptr   = (g + 1) % NUM_CH;
      m_valid = 1'b1;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: every consumed result is matched against the head of exp_q.
  always @(negedge clk) begin
    logic [CH_W+DATA_W:0] e;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result: unexpected result ch=%0d sum=%0d at %0t", out_ch, out_sum, $time);
      end else begin
        e = exp_q.pop_front();
        chk("result", {21'd0, out_primed, out_ch, out_sum}, {21'd0, e});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    clr = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk_sum("rst_out_sum", 0);
    chk("rst_out_ch", {30'd0, out_ch}, 32'd0);
    chk("rst_out_primed", {31'd0, out_primed}, 32'd0);
    req_valid = '1;
    #1;
    chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int pv[5];
    int ps[5];
    int pp[5];
    int rr[6];
    int iso0[4];
    int iso1[4];
    pv = '{10, 20, 30, 40, 50};
    ps = '{10, 30, 60, 100, -116};
    pp = '{0, 0, 0, 1, 1};
    rr = '{0, 1, 3, 0, 1, 3};
    iso0 = '{1, 3, 6, 10};
    iso1 = '{100, -56, 44, -112};

    // Priming and wrap on channel 0
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid = 4'b0001;
      set_sample(0, pv[i]);
      cycle();
      chk("prime_valid", {31'd0, out_valid}, 32'd1);
      chk_sum("prime_sum", ps[i]);
      chk("prime_primed", {31'd0, out_primed}, 32'(pp[i]));
      chk("prime_ch", {30'd0, out_ch}, 32'd0);
    end
    req_valid = '0;
    cycle();
    chk("prime_drained", {31'd0, out_valid}, 32'd0);

    // Round-robin over channels 0, 1, 3
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      req_data = $urandom;
      cycle();
      chk("rr_grant", {28'd0, last_rdy}, 32'(1 << rr[i]));
      chk("rr_ch", {30'd0, out_ch}, 32'(rr[i]));
    end
    req_valid = '0;

    // Backpressure with out_sum=30 pending
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0010;
    set_sample(1, 10);
    cycle();
    set_sample(1, 20);
    cycle();
    out_ready = 1'b0;
    set_sample(1, 5);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", {28'd0, last_rdy}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk_sum("bp_sum", 30);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_release_grant", {28'd0, last_rdy}, 32'b0010);
    chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
    chk_sum("bp_release_sum", 35);
    req_valid = '0;

    // Clear on channel 2
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0100;
    set_sample(2, 5);
    repeat (3) cycle();
    clr = 4'b0100;
    cycle();
    chk("clr_no_grant", {28'd0, last_rdy}, 32'd0);
    clr = '0;
    set_sample(2, 7);
    cycle();
    chk_sum("clr_sum", 7);
    chk("clr_primed", {31'd0, out_primed}, 32'd0);
    req_valid = '0;

    // Isolation between channels 0 and 1
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 4'b0001;
      set_sample(0, i + 1);
      cycle();
      chk_sum("iso_ch0_sum", iso0[i]);
      req_valid = 4'b0010;
      set_sample(1, 100);
      cycle();
      chk_sum("iso_ch1_sum", iso1[i]);
    end
    req_valid = '0;

    // Reset asserted between edges while a result is held
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'b0001;
    set_sample(0, 50);
    cycle();
    req_valid = '0;
    chk("mid_valid_before", {31'd0, out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("mid_ready_zero", {28'd0, req_ready}, 32'd0);
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 4'b0011;
    set_sample(0, 9);
    set_sample(1, 1);
    cycle();
    chk("mid_ptr_restart", {28'd0, last_rdy}, 32'b0001);
    chk_sum("mid_sum", 9);
    chk("mid_primed", {31'd0, out_primed}, 32'd0);
    req_valid = '0;
    cycle();

    // Random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      req_valid = NUM_CH'($urandom);
      req_data  = $urandom;
      for (int c = 0; c < NUM_CH; c++) clr[c] = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    req_valid = '0;
    clr = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
